fp32_multiplier: RTL and testbench
==================================

Name: fp32_multiplier

Overview:
- IEEE-754 single-precision multiplier: result = A × B with one registered output stage and status flags.
- Arithmetic leaf for neural-network MAC datapaths; consumes and produces raw 32-bit float words.
- Subnormals are flushed to zero; NaN outputs are canonical.

Parameters:
- None. Format is fixed to binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B are sampled at the clock edge when this is high
- A  input  32  operand A, binary32
- B  input  32  operand B, binary32
- result  output  32  registered product, binary32
- out_valid  output  1  high for one cycle when result and flags are updated
- overflow  output  1  finite operands produced a result rounded to ±inf
- underflow  output  1  nonzero finite operands produced a result flushed to ±0
- exception  output  1  invalid operation (NaN input, or inf × 0); result is NaN

Behaviour:
- Reset: while rst_n=0, all outputs are 0 (result=32'h0, out_valid=0, all flags=0). Reset takes effect immediately, independent of clk.
- Latency is 1 cycle. A/B are sampled on the rising edge where in_valid=1; result, flags and out_valid=1 appear after that same edge.
- A new operation may be issued every cycle. There is no backpressure.
- Edge with in_valid=0: out_valid←0; result and flags hold their previous values.
- Reset asserted mid-operation discards the in-flight operation.
- Sign: sign = A[31] XOR B[31]. This also applies to zero and inf results.
- Operand classification: exp=0 means zero (any nonzero fraction is treated as 0). exp=255 with frac=0 means inf. exp=255 with frac≠0 means NaN.
- Special cases, in priority order:
  - Either operand NaN → 32'h7FC00000, exception=1.
  - inf × 0 → 32'h7FC00000, exception=1.
  - inf × finite nonzero, or inf × inf → signed inf, no flags.
  - Zero × finite → signed zero, no flags.
- Normal path:
  - Mantissas are {1,frac}. Their 24×24 product is a 48-bit value.
  - The exponent is computed as Ea+Eb−127 in a signed 10-bit value.
  - If product bit 47 is set, shift right by 1 and increment the exponent.
  - Round the 24-bit significand (see Optional Feature). If rounding carries out, renormalize and increment the exponent.
- Result range:
  - Final exponent ≥255 → signed inf (exp=255, frac=0), overflow=1.
  - Final exponent ≤0 → signed zero, underflow=1.
- Flags are exclusive per operation; at most one is set.

Optional Feature:
- Macro: FPMUL_ROUND_NEAREST_EN.
- Defined: round-to-nearest-ties-to-even using guard, round and sticky bits taken from the discarded product bits.
- Undefined: truncation (round toward zero). Discarded bits are dropped and no rounding adder is present.
- Overflow/underflow detection is applied after rounding in both builds.

Test Plan:
- Exact products:
  - 32'hBF000000 × 32'hC0CCCCCC → 32'h404CCCCC.
  - 32'hBF000000 × 32'h40CCCCCC → 32'hC04CCCCC.
  - 32'h40000000 × 32'h40400000 → 32'h40C00000.
  - All three: out_valid one cycle after in_valid, all flags 0.
- Rounding: 32'h3FC00001 × 32'h3FC00001 → 32'h40100002 with FPMUL_ROUND_NEAREST_EN defined; 32'h40100001 without it.
- Overflow/underflow:
  - 32'h7F000000 × 32'h40000000 → 32'h7F800000, overflow=1.
  - 32'h00800000 × 32'h3F000000 → 32'h00000000, underflow=1.
- Specials:
  - 32'h7F800000 × 32'h00000000 → 32'h7FC00000, exception=1.
  - 32'h7FC00000 × 32'h3F800000 → 32'h7FC00000, exception=1.
  - 32'hFF800000 × 32'h40000000 → 32'hFF800000, no flags.
  - 32'h80000000 × 32'h3F800000 → 32'h80000000, no flags.
- Throughput and hold:
  - Back-to-back in_valid for 4 cycles → 4 consecutive correct results with out_valid held high.
  - in_valid=0 afterwards → out_valid=0 and result holds its last value.
- Reset: assert rst_n=0 between clock edges during a stream → outputs clear immediately to 0. After release, the first new in_valid yields a correct result one cycle later.

Source files
------------

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: binary32 multiplier with one registered output stage, flush-to-zero and canonical NaN.
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the significand is truncated.
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        out_valid,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [9:0] exp_b, exp_f;
    logic [22:0] frac;

    assign ea     = A[30:23];
    assign eb     = B[30:23];
    assign fa     = A[22:0];
    assign fb     = B[22:0];
    assign sign   = A[31] ^ B[31];
    assign a_zero = ea == 8'd0;
    assign b_zero = eb == 8'd0;
    assign a_inf  = ea == 8'hFF && fa == 23'd0;
    assign b_inf  = eb == 8'hFF && fb == 23'd0;
    assign a_nan  = ea == 8'hFF && fa != 23'd0;
    assign b_nan  = eb == 8'hFF && fb != 23'd0;
    assign exp_b  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

`ifdef FPMUL_ROUND_NEAREST_EN
    logic [47:0] prod;
    logic [23:0] sig;
    logic [24:0] sum;
    logic        g, r, s, hi;
    assign prod  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    assign hi    = prod[47];
    assign sig   = hi ? prod[47:24] : prod[46:23];
    assign g     = hi ? prod[23] : prod[22];
    assign r     = hi ? prod[22] : prod[21];
    assign s     = hi ? |prod[21:0] : |prod[20:0];
    assign sum   = {1'b0, sig} + {24'd0, g & (r | s | sig[0])};
    // A carry out of rounding leaves 1.000..., so renormalising just shifts in zeros.
    assign frac  = sum[24] ? sum[23:1] : sum[22:0];
    assign exp_f = exp_b + {9'd0, hi} + {9'd0, sum[24]};
`else
    logic [24:0] top;
    assign top   = 25'(({24'd0, 1'b1, fa} * {24'd0, 1'b1, fb}) >> 23);
    assign frac  = top[24] ? top[23:1] : top[22:0];
    assign exp_f = exp_b + {9'd0, top[24]};
`endif

    logic [31:0] n_res;
    logic        n_ovf, n_unf, n_exc;

    always_comb begin
        n_res = {sign, exp_f[7:0], frac};
        n_ovf = 1'b0;
        n_unf = 1'b0;
        n_exc = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            n_res = QNAN;
            n_exc = 1'b1;
        end else if (a_inf || b_inf) begin
            n_res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            n_res = {sign, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            n_res = {sign, 8'hFF, 23'd0};
            n_ovf = 1'b1;
        end else if (exp_f <= 10'sd0) begin
            n_res = {sign, 31'd0};
            n_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 32'd0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= n_res;
                overflow  <= n_ovf;
                underflow <= n_unf;
                exception <= n_exc;
            end
        end
    end
endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed vectors with hand-computed products for fp32_multiplier.
module tb_fp32_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A, B;
    logic [31:0] result;
    logic        out_valid, overflow, underflow, exception;
    int checks = 0;
    int errors = 0;

    fp32_multiplier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .result(result), .out_valid(out_valid), .overflow(overflow),
        .underflow(underflow), .exception(exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] r, input logic v, input logic o, input logic u, input logic e);
        checks++;
        assert ({result, out_valid, overflow, underflow, exception} === {r, v, o, u, e})
        else begin
            errors++;
            $error("FAIL %s: observed res=%h v=%b ovf=%b unf=%b exc=%b expected res=%h v=%b ovf=%b unf=%b exc=%b",
                   tag, result, out_valid, overflow, underflow, exception, r, v, o, u, e);
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic o, input logic u, input logic e);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(tag, r, 1'b1, o, u, e);
    endtask

    logic [31:0] va [4] = '{32'h40000000, 32'h3F800000, 32'hC0000000, 32'h3FC00000};
    logic [31:0] vb [4] = '{32'h40400000, 32'h3F800000, 32'h3F000000, 32'h3FC00000};
    logic [31:0] vr [4] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h40100000};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = 32'd0; B = 32'd0;
        #1 chk("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        op("exact_pos", 32'hBF000000, 32'hC0CCCCCC, 32'h404CCCCC, 0, 0, 0);
        op("exact_neg", 32'hBF000000, 32'h40CCCCCC, 32'hC04CCCCC, 0, 0, 0);
        op("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
`ifdef FPMUL_ROUND_NEAREST_EN
        op("rounding", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 0, 0, 0);
`else
        op("rounding", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 0, 0, 0);
`endif
        op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 0);
        op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0);
        op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1);
        op("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1);
        op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0);
        op("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A = va[i]; B = vb[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("stream%0d", i), vr[i], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk); in_valid = 1'b0; A = 32'h40000000; B = 32'h40000000;
        @(posedge clk); #1;
        chk("hold", 32'h40100000, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk); A = 32'h40000000; B = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset", 32'h40C00000, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("reset_held", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        op("after_reset", 32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
